// File: rtl/muldiv_div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU): restoring division,
// one quotient bit per cycle, with a Start/Busy/Done handshake for the hazard unit.
module muldiv_div_unit #(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [1:0]      DivOpE,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] DivResultE,
  output logic [3:0]      Flags,
  output logic [1:0]      state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Handshake: Start is accepted on an edge only while Busy is low (IDLE or DONE);
  // Done is high for exactly one cycle and DivResultE/Flags hold until the next FIX.
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] dmag;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;
  logic [CNTW-1:0] cnt;
  logic            neg_q;
  logic            neg_r;
  logic            dz;
  logic            ovf;

  logic            in_signed;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            dz_in;
  logic            ovf_in;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] res_fix;
  logic            c_fix;
  logic            v_fix;

  assign in_signed = ~DivOpE[0];
  assign a_mag     = (in_signed && A[XLEN-1]) ? -A : A;
  assign b_mag     = (in_signed && B[XLEN-1]) ? -B : B;
  assign dz_in     = (B == '0);
  assign ovf_in    = in_signed && (A == INT_MIN) && (B == '1);

  // Restoring step: shift {rem, quo} left, then trial-subtract the divisor magnitude.
  assign rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dmag};

  always_comb begin
    res_fix = '0;
    c_fix   = 1'b0;
    v_fix   = 1'b0;
    if (dz) begin
      c_fix   = 1'b1;
      res_fix = op_q[1] ? a_q : '1;
    end else if (ovf) begin
      v_fix   = 1'b1;
      res_fix = op_q[1] ? '0 : INT_MIN;
    end else if (op_q[1]) begin
      res_fix = (!op_q[0] && neg_r) ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    end else begin
      res_fix = (!op_q[0] && neg_q) ? -quo : quo;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      dmag       <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dz         <= 1'b0;
      ovf        <= 1'b0;
      DivResultE <= '0;
      Flags      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            op_q  <= DivOpE;
            a_q   <= A;
            dmag  <= b_mag;
            rem   <= '0;
            quo   <= a_mag;
            cnt   <= '1;
            neg_q <= A[XLEN-1] ^ B[XLEN-1];
            neg_r <= A[XLEN-1];
            dz    <= dz_in;
            ovf   <= ovf_in;
            state <= (dz_in || ovf_in) ? FIX : CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem   <= trial[XLEN] ? rem_sh : trial;
          quo   <= {quo[XLEN-2:0], ~trial[XLEN]};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          DivResultE <= res_fix;
          Flags      <= {(res_fix == '0), c_fix, v_fix, res_fix[XLEN-1]};
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == CALC) || (state == FIX);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_muldiv_div_unit.sv
// Bench for muldiv_div_unit: directed test-plan vectors, handshake, back-to-back,
// mid-operation reset and randomized operations against an arithmetic reference model.
module tb_muldiv_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  DivOpE = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] DivResultE;
  logic [3:0]  Flags;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  logic [35:0] exp_q[$];
  int          lat_q[$];

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  muldiv_div_unit #(.XLEN(32), .CNTW(5)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .DivOpE(DivOpE), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivResultE(DivResultE), .Flags(Flags), .state(state)
  );

  always #5 CLK = ~CLK;

  // Reference: RV32M semantics from plain integer arithmetic; returns {flags, result}.
  function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c, v;
    int sa, sb;
    sa = a;
    sb = b;
    c = 1'b0;
    v = 1'b0;
    if (b == 0) begin
      c = 1'b1;
      r = op[1] ? a : 32'hFFFF_FFFF;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      v = 1'b1;
      r = op[1] ? 32'h0 : 32'h8000_0000;
    end else begin
      case (op)
        OP_DIV:  r = sa / sb;
        OP_DIVU: r = a / b;
        OP_REM:  r = sa % sb;
        default: r = a % b;
      endcase
    end
    return {(r == 0), c, v, r[31], r};
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [35:0] exp, input int exp_lat);
    DivOpE = op;
    A      = a;
    B      = b;
    Start  = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(exp_lat);
  endtask

  // Counts edges from the accepting edge until Done is seen; optionally disturbs inputs mid-run.
  task automatic collect(input string name, input bit disturb);
    int lat;
    bit busy_bad;
    logic [35:0] exp;
    int el;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    Start = 1'b0;
    busy_bad = 1'b0;
    while (!Done && lat < 100) begin
      if (Busy !== 1'b1) busy_bad = 1'b1;
      if (disturb && lat == 10) begin
        Start = 1'b1; DivOpE = OP_DIV; A = 32'd9; B = 32'd3;
      end else if (disturb && lat == 11) begin
        Start = 1'b0; A = $urandom; B = $urandom; DivOpE = 2'($urandom_range(0, 3));
      end
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    exp = exp_q.pop_front();
    el  = lat_q.pop_front();
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("FAIL %s done_timeout: got lat=%0d without Done", name, lat);
    end
    checks++;
    if (lat != el) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, el);
    end
    checks++;
    if (DivResultE !== exp[31:0]) begin
      errors++; $display("FAIL %s result: got %h expected %h", name, DivResultE, exp[31:0]);
    end
    checks++;
    if (Flags !== exp[35:32]) begin
      errors++; $display("FAIL %s flags: got %b expected %b", name, Flags, exp[35:32]);
    end
    checks++;
    if (busy_bad || Busy !== 1'b0) begin
      errors++; $display("FAIL %s busy: got busy_bad=%0d busy_at_done=%b expected 0/0", name, busy_bad, Busy);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    Start = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: got busy=%b done=%b expected 0 0", Busy, Done);
    end
    checks++;
    if (DivResultE !== 32'h0 || Flags !== 4'h0) begin
      errors++; $display("FAIL reset_outputs: got %h/%b expected 0/0", DivResultE, Flags);
    end
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    Start = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    issue(OP_DIVU, 32'd100, 32'd7, {4'b0000, 32'd14}, 34);                   collect("divu_100_7", 1'b0);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, {4'b0001, 32'hFFFF_FFFF}, 34);        collect("rem_m7_2", 1'b0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, {4'b0001, 32'hFFFF_FFFD}, 34);        collect("div_m7_2", 1'b0);
    issue(OP_DIVU, 32'h1234, 32'd0, {4'b0101, 32'hFFFF_FFFF}, 2);             collect("divu_dz", 1'b0);
    issue(OP_REMU, 32'h1234, 32'd0, {4'b0100, 32'h0000_1234}, 2);             collect("remu_dz", 1'b0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {4'b0011, 32'h8000_0000}, 2); collect("div_ovf", 1'b0);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, {4'b1010, 32'h0}, 2);         collect("rem_ovf", 1'b0);
  endtask

  task automatic test_handshake();
    issue(OP_DIVU, 32'd50, 32'd5, {4'b0000, 32'd10}, 34);
    collect("handshake", 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || DivResultE !== 32'd10) begin
      errors++; $display("FAIL done_pulse: got done=%b busy=%b res=%h expected 0 0 0000000a", Done, Busy, DivResultE);
    end
  endtask

  task automatic test_back_to_back();
    issue(OP_DIVU, 32'd77, 32'd7, {4'b0000, 32'd11}, 34);              collect("b2b_first", 1'b0);
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, {4'b0001, 32'hFFFF_FFF2}, 34); collect("b2b_second", 1'b0);
    issue(OP_REMU, 32'd5, 32'd0, {4'b0100, 32'd5}, 2);                 collect("b2b_special", 1'b0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {4'b0011, 32'h8000_0000}, 2); collect("b2b_special2", 1'b0);
    issue(OP_REMU, 32'd47, 32'd10, {4'b0000, 32'd7}, 34);              collect("b2b_after_special", 1'b0);
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    DivOpE = OP_DIVU; A = 32'd1000; B = 32'd3; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    saw_done = 1'b0;
    repeat (19) begin
      @(posedge CLK);
      @(negedge CLK);
      if (Done) saw_done = 1'b1;
    end
    RST = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL midreset_handshake: got busy=%b done=%b expected 0 0", Busy, Done);
    end
    checks++;
    if (DivResultE !== 32'h0 || Flags !== 4'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h/%b expected 0/0", DivResultE, Flags);
    end
    repeat (2) begin
      @(negedge CLK);
      if (Done) saw_done = 1'b1;
    end
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (Done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL midreset_no_done: got Done pulse expected none");
    end
    issue(OP_DIVU, 32'd1000, 32'd3, {4'b0000, 32'd333}, 34);
    collect("after_reset", 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, model(op, a, b), model_lat(op, a, b));
      collect($sformatf("random_%0d", i), 1'b0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
